// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: framebuffer pixel-fetch bus between the timing generator and the pixel source
//   master (timing generator): pix_req/pix_x/pix_y out, pix_rgb in
//   slave  (pixel source)    : pix_req/pix_x/pix_y in,  pix_rgb out
interface vga_timing_gen_if #(
   parameter int unsigned RGB_W = 3
);
   logic             pix_req;
   logic [9:0]       pix_x;
   logic [9:0]       pix_y;
   logic [RGB_W-1:0] pix_rgb;
   modport master (output pix_req, pix_x, pix_y, input pix_rgb);
   modport slave  (input pix_req, pix_x, pix_y, output pix_rgb);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA hsync/vsync timing with a two-stage pixel fetch/output pipeline
//   clk           pixel clock
//   reset         asynchronous active-high reset
//   en_i          run enable; low holds the counters and blanks the pipeline
//   pix           fetch bus (pix_req/pix_x/pix_y out, pix_rgb in one clock later)
//   vga_rgb_o     pixel output, 0 while blanked
//   vga_hsync_o   horizontal sync, asserted level SYNC_POL
//   vga_vsync_o   vertical sync, asserted level SYNC_POL
//   frame_start_o one-clock pulse when pixel (0,0) is on vga_rgb_o
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned RGB_W    = 3
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   vga_timing_gen_if.master pix,
   output logic [RGB_W-1:0] vga_rgb_o,
   output logic             vga_hsync_o,
   output logic             vga_vsync_o,
   output logic             frame_start_o
);
   localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
   logic             active, hs_on, vs_on;
   logic             act_q, hs_q, vs_q;
   logic [9:0]       x_q, y_q;
   logic [RGB_W-1:0] rgb_q;
   logic             hsync_q, vsync_q, fs_q;

   always_comb begin
      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (en_i) begin
         h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 10'd1;
         if (h_cnt_q == H_LAST) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
   end

   // en gates the region flags so a paused generator feeds blanking into the pipeline
   assign active = en_i && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign hs_on  = en_i && (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
   assign vs_on  = en_i && (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
         act_q   <= 1'b0;
         hs_q    <= 1'b0;
         vs_q    <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         rgb_q   <= '0;
         hsync_q <= !SYNC_POL;
         vsync_q <= !SYNC_POL;
         fs_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         act_q   <= active;
         hs_q    <= hs_on;
         vs_q    <= vs_on;
         x_q     <= active ? h_cnt_q : '0;
         y_q     <= active ? v_cnt_q : '0;
         rgb_q   <= act_q ? pix.pix_rgb : '0;
         hsync_q <= hs_q ? SYNC_POL : !SYNC_POL;
         vsync_q <= vs_q ? SYNC_POL : !SYNC_POL;
         fs_q    <= act_q && (x_q == '0) && (y_q == '0);
      end
   end

   assign pix.pix_req   = act_q;
   assign pix.pix_x     = x_q;
   assign pix.pix_y     = y_q;
   assign vga_rgb_o     = rgb_q;
   assign vga_hsync_o   = hsync_q;
   assign vga_vsync_o   = vsync_q;
   assign frame_start_o = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed table-driven bench for vga_timing_gen on an 8x6 timing
module tb_vga_timing_gen;
   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [2:0] vga_rgb;
   logic       vga_hsync, vga_vsync, frame_start;
   int         errors = 0;
   int         checks = 0;

   vga_timing_gen_if #(.RGB_W(3)) pif ();

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0), .RGB_W(3)
   ) dut (
      .clk(clk), .reset(reset), .en_i(en), .pix(pif.master),
      .vga_rgb_o(vga_rgb), .vga_hsync_o(vga_hsync), .vga_vsync_o(vga_vsync),
      .frame_start_o(frame_start)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic req;
      int   x;
      int   y;
      int   rgb;
      logic hs;
      logic vs;
      logic fs;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic pins(input string tag, input vec_t v);
      chk({tag, ".req"}, 32'(pif.pix_req), 32'(v.req));
      if (v.req) chk({tag, ".x"}, 32'(pif.pix_x), v.x);
      if (v.req) chk({tag, ".y"}, 32'(pif.pix_y), v.y);
      chk({tag, ".rgb"}, 32'(vga_rgb), v.rgb);
      chk({tag, ".hs"}, 32'(vga_hsync), 32'(v.hs));
      chk({tag, ".vs"}, 32'(vga_vsync), 32'(v.vs));
      chk({tag, ".fs"}, 32'(frame_start), 32'(v.fs));
   endtask

   // pixel source: answers a request with x+1, drives 3'b111 when nothing was asked
   task automatic tick();
      @(posedge clk);
      #1;
      pif.pix_rgb = pif.pix_req ? 3'(pif.pix_x + 10'd1) : 3'b111;
   endtask

   task automatic run_from_reset(input string tag);
      pins({tag, "[0]"}, tbl[0]);
      reset = 1'b0;
      for (int i = 1; i < 12; i++) begin
         tick();
         pins($sformatf("%s[%0d]", tag, i), tbl[i]);
      end
   endtask

   initial begin
      int n_req, n_vs, n_fs, first_vs, fs_a, fs_b, exp_rgb, d, h, v;
      tbl[0]  = '{1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 0, 0, 0, 1'b1, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 1, 0, 1, 1'b1, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 2, 0, 2, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 3, 0, 3, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 0, 0, 4, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 0, 1, 0, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 1, 1, 1, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{1'b1, 2, 1, 2, 1'b1, 1'b1, 1'b0};
      reset = 1'b1;
      en = 1'b1;
      pif.pix_rgb = 3'b111;
      repeat (3) tick();
      run_from_reset("rst");

      reset = 1'b1;
      tick();
      n_req = 0; n_vs = 0; n_fs = 0; first_vs = -1; fs_a = -1; fs_b = -1;
      reset = 1'b0;
      for (int n = 1; n <= 50; n++) begin
         tick();
         if (n <= 48 && pif.pix_req) n_req++;
         if (!vga_vsync) begin
            n_vs++;
            if (first_vs < 0) first_vs = n;
         end
         if (frame_start) begin
            n_fs++;
            if (fs_a < 0) fs_a = n; else fs_b = n;
         end
         d = n - 2;
         h = (d < 0) ? 7 : d % 8;
         v = (d < 0) ? 0 : (d / 8) % 6;
         exp_rgb = (h < 4 && v < 3) ? h + 1 : 0;
         chk($sformatf("frame.rgb[%0d]", n), 32'(vga_rgb), exp_rgb);
      end
      chk("frame.req_count", n_req, 12);
      chk("frame.vs_count", n_vs, 8);
      chk("frame.vs_first", first_vs, 34);
      chk("frame.fs_count", n_fs, 2);
      chk("frame.fs_first", fs_a, 2);
      chk("frame.fs_second", fs_b, 50);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      chk("en.pre_req", 32'(pif.pix_req), 1);
      chk("en.pre_x", 32'(pif.pix_x), 1);
      chk("en.pre_y", 32'(pif.pix_y), 1);
      en = 1'b0;
      tick();
      chk("en.c11_req", 32'(pif.pix_req), 0);
      chk("en.c11_rgb", 32'(vga_rgb), 2);
      for (int n = 12; n <= 15; n++) begin
         tick();
         chk($sformatf("en.c%0d_req", n), 32'(pif.pix_req), 0);
         chk($sformatf("en.c%0d_rgb", n), 32'(vga_rgb), 0);
         chk($sformatf("en.c%0d_hs", n), 32'(vga_hsync), 1);
         chk($sformatf("en.c%0d_vs", n), 32'(vga_vsync), 1);
      end
      en = 1'b1;
      tick();
      chk("en.resume_req", 32'(pif.pix_req), 1);
      chk("en.resume_x", 32'(pif.pix_x), 2);
      chk("en.resume_y", 32'(pif.pix_y), 1);
      n_fs = 0;
      tick();
      chk("en.resume_rgb", 32'(vga_rgb), 3);
      chk("en.resume_x2", 32'(pif.pix_x), 3);
      for (int n = 18; n <= 45; n++) begin
         tick();
         if (frame_start) n_fs++;
      end
      chk("en.no_extra_fs", n_fs, 0);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (19) tick();
      chk("mid.pre_rgb", 32'(vga_rgb), 2);
      reset = 1'b1;
      #1;
      chk("mid.rgb", 32'(vga_rgb), 0);
      chk("mid.hs", 32'(vga_hsync), 1);
      chk("mid.vs", 32'(vga_vsync), 1);
      chk("mid.req", 32'(pif.pix_req), 0);
      tick();
      run_from_reset("restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Transmitter end of the SoC VGA interface: generates hsync/vsync timing and drives vga_rgb from pixel data fetched from the framebuffer.
- Sits between the framebuffer read port and the vga_rgb/vga_hsync/vga_vsync pins, clocked by the pixel clock (vga_clk domain).
- Issues one pixel request per active pixel and accepts data one cycle later (registered RAM read).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low)
- RGB_W, 3, colour bits per pixel

Ports:
- clk  in  1  pixel clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- en  in  1  run enable; low freezes counters and blanks outputs
- pix_req  out  1  pixel fetch strobe, high for exactly one clock per visible pixel
- pix_x  out  10  column of the requested pixel, valid while pix_req is high
- pix_y  out  10  row of the requested pixel, valid while pix_req is high
- pix_rgb  in  RGB_W  pixel data, sampled on the clock after pix_req
- vga_rgb  out  RGB_W  pixel output, 0 when blanked
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- frame_start  out  1  one-clock pulse when the first pixel (0,0) appears on vga_rgb

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Both wrap to 0; v_cnt wraps when h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1 in the same clock.
- Regions:
  - Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync changes only at line boundaries, i.e. aligned with h_cnt==0.
- Pipeline stage 1 (registered from the counters):
  - pix_req = active & en.
  - pix_x = h_cnt and pix_y = v_cnt when active, else 0.
  - Delayed sync and active flags are carried alongside.
- Pipeline stage 2 (registered):
  - vga_rgb = pix_rgb if the stage-1 active flag was set, else 0.
  - vga_hsync and vga_vsync take the stage-1 sync flags (asserted level = SYNC_POL).
  - frame_start = stage-1 active flag with x==0, y==0.
- Latency:
  - Counter state to pins: 2 clocks.
  - pix_req to pixel on vga_rgb: 1 clock. The source must present pix_rgb in the clock after pix_req; pix_rgb is ignored at all other times.
  - Syncs and rgb are mutually aligned at the pins.
- en low:
  - Counters hold their values.
  - Pipeline inputs are forced inactive: pix_req=0, rgb=0, syncs deasserted (at !SYNC_POL).
  - Blanking reaches the pins after the 2-clock pipeline.
  - When en rises again, counting resumes from the held position; there is no frame restart.
- Reset values:
  - h_cnt=0, v_cnt=0, pix_req=0, pix_x=0, pix_y=0.
  - vga_rgb=0, vga_hsync=!SYNC_POL, vga_vsync=!SYNC_POL, frame_start=0.
  - Reset mid-frame aborts immediately. After release, the first frame starts at (0,0): the first pix_req is on the first clock edge after release with en=1.
- Widths: counters are 10 bits; parameter totals up to 1023 are legal. Totals above 1023 are a configuration error with no defined behaviour.

Test Plan:
Common setup: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8); V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6); SYNC_POL=0; en=1; the source returns pix_rgb = pix_x+1 one clock after each request.
1. Reset released (reset 1→0) -> before release, pins read vga_rgb=0, hsync=1, vsync=1. First pix_req has (x,y)=(0,0). Two clocks after release, vga_rgb=3'b001 with frame_start=1 for exactly 1 clock.
2. One full line -> pix_req high 4 clocks, then low 4 clocks. vga_rgb sequence per line is 1,2,3,4,0,0,0,0. vga_hsync is low for exactly 2 clocks, starting 5 clocks after the line's first pixel on vga_rgb.
3. One full frame (48 clocks) -> exactly 12 pix_req pulses. vga_vsync is low for exactly 8 clocks, covering line 4 only. frame_start pulses again 48 clocks after the first pulse.
4. en dropped for 5 clocks at h_cnt=2 on line 1 -> within 2 clocks, rgb=0 and syncs=1. After en rises, pix_x resumes at 2 on line 1; no extra frame_start pulse.
5. Reset asserted mid-line at (x=3, y=2) -> immediately vga_rgb=0, syncs=1, pix_req=0. After release, the sequence restarts exactly as in scenario 1.
6. pix_rgb driven to 3'b111 outside the clocks following pix_req -> vga_rgb stays 0 in all blanking clocks.
